rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Registered, handshaked N-to-1 multiplexer. It selects one of DEPTH input channels per cycle, using either round-robin or fixed-priority arbitration, and drives a one-entry output register with valid/ready flow control. It replaces the combinational address-select multiplexer wherever several HWAG producers (capture, comparator, timer event sources) share one downstream consumer. In those cases the consumer cannot tolerate a combinational path from select to data, and no producer may be starved.

## Interface
Parameters:
- WIDTH, 8: data width per channel.
- DEPTH, 4: channel count, ≥1.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- ADDR_WIDTH, derived localparam: max(1, $clog2(DEPTH)).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d  in  [WIDTH-1:0] × [DEPTH-1:0]  per-channel data, unpacked array indexed by channel.
- in_valid  in  DEPTH  per-channel data-valid.
- in_ready  out  DEPTH  per-channel accept strobe, combinational.
- out_data  out  WIDTH  registered selected data.
- out_addr  out  ADDR_WIDTH  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts out_data this cycle.

## Operation
- Transfer rules:
  - Input transfer on channel i: in_valid[i] & in_ready[i] at a clock edge.
  - Output transfer: out_valid & out_ready at a clock edge.
- Load enable: load = ~out_valid | out_ready. The output register can accept a word when it is empty or is being drained in the same cycle.
- Grant is combinational:
  - RR=0: grant goes to the lowest-index i with in_valid[i].
  - RR=1: search starts at index (last+1) mod DEPTH, wraps through DEPTH-1 to 0, and ends at last. The first valid channel found wins.
  - At most one grant bit is set. No grant is issued when in_valid is 0.
- in_ready[i] = grant[i] & load. in_ready never asserts for a channel whose in_valid is low.
- On an input transfer:
  - out_data <= d[i], out_addr <= i, out_valid <= 1.
  - last <= i, only when RR=1.
- Output transfer with no input transfer in the same cycle: out_valid <= 0. out_data and out_addr hold their values.
- Simultaneous output and input transfer: the new word replaces the old word with no bubble.
- out_valid=1 & out_ready=0 (stall):
  - All in_ready are 0.
  - out_data, out_addr and last are frozen.
  - The grant may change while stalled. The stalled word is unaffected.
- last is updated only on an actual input transfer, never on a grant that does not complete.
- DEPTH=1: the arbiter degenerates. grant[0] = in_valid[0] and out_addr is constant 0.
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_addr=0.
  - last=DEPTH-1, so channel 0 has top priority on the first cycle after reset.
  - in_ready is all zeros while rst=1, taking priority over load.
  - Reset mid-stall discards the held word. No transfer is reported on that edge.

## Timing
- Latency: one cycle from an input transfer to out_valid=1 with that word.
- Throughput: one word per cycle while out_ready is held high.
- Combinational paths:
  - in_valid, out_ready → in_ready.
  - None from d to any output. out_data and out_addr come directly from flops.
- Fairness with RR=1: with all DEPTH channels continuously valid and out_ready=1, each channel is served exactly once per DEPTH consecutive transfers.

## Test plan
- Reset: hold rst for 2 cycles with all in_valid=1. Required: out_valid=0, out_data=0, out_addr=0, in_ready=0. On the first cycle after reset, in_ready=4'b0001 and channel 0's data appears one cycle later.
- Round-robin sweep (DEPTH=4, RR=1): all valid with d[i]=8'hA0+i, out_ready=1. Required out_addr sequence is 0,1,2,3,0,1 and out_data is A0,A1,A2,A3,A0,… with no bubbles.
- Fixed priority (RR=0): in_valid=4'b1010 for 4 cycles. Required: out_addr=1 on every transfer, and channel 3 is never granted.
- Backpressure: a word from channel 2 is held with out_ready=0 for 3 cycles while in_valid changes. Required: out_data, out_addr=2 and out_valid=1 are stable, and in_ready=0 throughout. Releasing out_ready gives a new word on the next cycle with no gap.
- Pointer wrap and skip: after a grant to channel 3, set in_valid=4'b1001. Required: the next grant goes to channel 0, then 3, then 0.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0. Required: out_valid=0 on the next edge, and the next grant goes to channel 0 regardless of the prior value of last.

Source files
------------

// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rr_stream_mux
//  Brief    : Registered valid/ready N-to-1 stream mux with round-robin or
//             fixed-priority arbitration and a one-entry output register.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_stream_mux #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int RR    = 1,
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      d [DEPTH],
    input  logic [DEPTH-1:0]      in_valid,
    output logic [DEPTH-1:0]      in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [ADDR_WIDTH-1:0] c_last_rst = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0]      r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_last;

    logic [DEPTH-1:0]      w_grant;
    logic                  w_any;
    logic                  w_load;
    logic                  w_xfer;
    logic [WIDTH-1:0]      w_sel_data;
    logic [ADDR_WIDTH-1:0] w_sel_idx;

    assign w_load = ~r_valid | out_ready;
    assign w_xfer = w_any & w_load & ~rst;

    // Each valid channel gets a distance from the search start; smallest wins.
    always_comb begin
        int v_start;
        int v_dist;
        int v_best;
        int v_sel;
        v_start = 0;
        v_dist  = 0;
        v_best  = DEPTH;
        v_sel   = 0;
        if (RR != 0) begin
            v_start = (int'(r_last) + 1) % DEPTH;
        end
        for (int i = 0; i < DEPTH; i++) begin
            v_dist = (i + DEPTH - v_start) % DEPTH;
            if (in_valid[i] && (v_dist < v_best)) begin
                v_best = v_dist;
                v_sel  = i;
            end
        end
        w_any     = (v_best < DEPTH);
        w_sel_idx = ADDR_WIDTH'(v_sel);
        w_grant   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_grant[i] = w_any && (v_sel == i);
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_data = d[i];
            end
        end
    end

    assign in_ready = rst ? '0 : (w_grant & {DEPTH{w_load}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_last  <= c_last_rst;
        end else if (w_xfer) begin
            r_data  <= w_sel_data;
            r_addr  <= w_sel_idx;
            r_valid <= 1'b1;
            if (RR != 0) begin
                r_last <= w_sel_idx;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_addr  = r_addr;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_stream_mux
//  Brief    : Bench for rr_stream_mux; round-robin and fixed-priority copies
//             driven in parallel and compared to a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_mux;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d [N];
    logic [N-1:0] in_valid;
    logic         out_ready;

    logic [N-1:0] rdy_rr, rdy_fp;
    logic [W-1:0] data_rr, data_fp;
    logic [1:0]   addr_rr, addr_fp;
    logic         val_rr, val_fp;

    int n_cmp = 0;
    int n_bad = 0;

    // model state, index 0 = round-robin copy, 1 = fixed-priority copy
    bit           m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_addr  [2];
    int           m_last  [2];

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(W), .DEPTH(N), .RR(1)) dut_rr (
        .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(rdy_rr),
        .out_data(data_rr), .out_addr(addr_rr), .out_valid(val_rr), .out_ready(out_ready)
    );

    rr_stream_mux #(.WIDTH(W), .DEPTH(N), .RR(0)) dut_fp (
        .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(rdy_fp),
        .out_data(data_fp), .out_addr(addr_fp), .out_valid(val_fp), .out_ready(out_ready)
    );

    typedef struct {
        bit           rst;
        logic [N-1:0] iv;
        bit           ordy;
        logic [N-1:0] rdy;
        bit           val;
        logic [1:0]   addr;
        logic [W-1:0] data;
    } vec_t;

    vec_t tv [22];

    // Winner: first valid channel visiting last+1, last+2, ... (RR) or 0,1,... (fixed)
    function automatic int pick(bit rr, int last, logic [N-1:0] v);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = rr ? (last + k) % N : k - 1;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare combinational ready, clock once, advance the model, compare outputs.
    task automatic step();
        logic [N-1:0] er [2];
        int g;
        bit ld;
        #1;
        for (int j = 0; j < 2; j++) begin
            g  = pick(j == 0, m_last[j], in_valid);
            ld = !m_valid[j] || out_ready;
            er[j] = (!rst && g >= 0 && ld) ? N'(1 << g) : '0;
        end
        check("rr in_ready", 32'(rdy_rr), 32'(er[0]));
        check("fp in_ready", 32'(rdy_fp), 32'(er[1]));
        @(posedge clk);
        for (int j = 0; j < 2; j++) begin
            g  = pick(j == 0, m_last[j], in_valid);
            ld = !m_valid[j] || out_ready;
            if (rst) begin
                m_valid[j] = 1'b0; m_data[j] = '0; m_addr[j] = 0; m_last[j] = N - 1;
            end else if (g >= 0 && ld) begin
                m_valid[j] = 1'b1; m_data[j] = d[g]; m_addr[j] = g;
                if (j == 0) m_last[j] = g;
            end else if (out_ready) begin
                m_valid[j] = 1'b0;
            end
        end
        #1;
        check("rr out_valid", 32'(val_rr), 32'(m_valid[0]));
        check("rr out_data",  32'(data_rr), 32'(m_data[0]));
        check("rr out_addr",  32'(addr_rr), 32'(m_addr[0]));
        check("fp out_valid", 32'(val_fp), 32'(m_valid[1]));
        check("fp out_data",  32'(data_fp), 32'(m_data[1]));
        check("fp out_addr",  32'(addr_fp), 32'(m_addr[1]));
    endtask

    initial begin
        // {rst, in_valid, out_ready, exp in_ready, exp out_valid, exp out_addr, exp out_data}
        tv = '{
            '{1'b1, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00},  // reset, all valid
            '{1'b1, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00},
            '{1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0},  // round-robin sweep
            '{1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1},
            '{1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2},
            '{1'b0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3},
            '{1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0},
            '{1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1},
            '{1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2},  // ch2 word, then stall
            '{1'b0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2},
            '{1'b0, 4'h3, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2},
            '{1'b0, 4'h8, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2},
            '{1'b0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3},  // release, no gap
            '{1'b0, 4'h9, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0},  // wrap and skip
            '{1'b0, 4'h9, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3},
            '{1'b0, 4'h9, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0},
            '{1'b0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0},  // drain, data held
            '{1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'hA0},
            '{1'b0, 4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2},
            '{1'b0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2},  // stall ...
            '{1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00},  // ... reset mid-stall
            '{1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0}
        };

        m_valid = '{0, 0}; m_data = '{8'h00, 8'h00}; m_addr = '{0, 0}; m_last = '{N - 1, N - 1};
        for (int i = 0; i < N; i++) d[i] = 8'hA0 + 8'(i);
        rst = 1'b1; in_valid = '0; out_ready = 1'b0;

        for (int i = 0; i < 22; i++) begin
            rst = tv[i].rst; in_valid = tv[i].iv; out_ready = tv[i].ordy;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(rdy_rr), 32'(tv[i].rdy));
            step();
            check($sformatf("vec%0d out_valid", i), 32'(val_rr), 32'(tv[i].val));
            check($sformatf("vec%0d out_addr", i), 32'(addr_rr), 32'(tv[i].addr));
            check($sformatf("vec%0d out_data", i), 32'(data_rr), 32'(tv[i].data));
        end

        // fixed priority: channel 1 always beats channel 3
        in_valid = 4'b1010; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fixed in_ready", 32'(rdy_fp), 32'(4'b0010));
            step();
            check("fixed out_addr", 32'(addr_fp), 32'd1);
            check("fixed out_data", 32'(data_fp), 32'hA1);
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) d[k] = W'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
